// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle: scan enable, BCD word and masks in; nibble, anodes and frame strobe out.
interface seg_scan_mux_if
    import scan_pkg::*;
#(
    parameter int DIGITS = 4
) ();

    localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);

    logic                  en;
    logic [4*DIGITS-1:0]   digits_bcd;
    logic                  lz_suppress;
    logic [DIGITS-1:0]     blank_mask;
    logic [3:0]            bcd_out;
    logic [DIGITS-1:0]     an_n;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_tick;

    modport master (
        output en, digits_bcd, lz_suppress, blank_mask,
        input  bcd_out, an_n, digit_idx, frame_tick
    );

    modport slave (
        input  en, digits_bcd, lz_suppress, blank_mask,
        output bcd_out, an_n, digit_idx, frame_tick
    );

endinterface

// File: rtl/seg_scan_mux_lz_mask.sv
// Per-digit blanking decision: forced mask, illegal BCD, and leading-zero suppression.
module seg_lz_mask #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] digits,
    input  logic                lz_suppress,
    input  logic [DIGITS-1:0]   blank_mask,
    output logic [DIGITS-1:0]   blank
);

    logic [3:0] nib;
    logic       zero_above;

    // Walk from the most significant digit down so zero_above means "this and all higher are 0".
    always_comb begin
        blank      = '0;
        nib        = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib        = digits[4*(DIGITS-1-k) +: 4];
            zero_above = zero_above && (nib == 4'd0);
            blank[DIGITS-1-k] = blank_mask[DIGITS-1-k] || (nib > 4'd9)
                              || (lz_suppress && (k + 1 < DIGITS) && zero_above);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scan driver: per-frame input snapshot, per-slot dead-time then display.
module seg_scan_mux
    import scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave scan
);

    localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("seg_scan_mux: DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= DIV) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYC must satisfy 0 <= BLANK_CYC < DIV");
    end

    scan_state_t         state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [4*DIGITS-1:0] snap_digits, snap_digits_nxt;
    logic                snap_lz, snap_lz_nxt;
    logic [DIGITS-1:0]   snap_mask, snap_mask_nxt;
    logic                tick_q, tick_nxt;
    logic [DIGITS-1:0]   an_q, an_nxt;
    logic [3:0]          bcd_q, bcd_nxt;
    logic [DIGITS-1:0]   blank_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_lz     <= 1'b0;
            snap_mask   <= '0;
            tick_q      <= 1'b0;
            an_q        <= '1;
            bcd_q       <= BCD_BLANK;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            snap_digits <= snap_digits_nxt;
            snap_lz     <= snap_lz_nxt;
            snap_mask   <= snap_mask_nxt;
            tick_q      <= tick_nxt;
            an_q        <= an_nxt;
            bcd_q       <= bcd_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        idx_nxt         = idx;
        snap_digits_nxt = snap_digits;
        snap_lz_nxt     = snap_lz;
        snap_mask_nxt   = snap_mask;
        tick_nxt        = 1'b0;
        if (!scan.en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            if (state == IDLE || (cnt == CNT_LAST && idx == IDX_LAST)) begin
                cnt_nxt         = '0;
                idx_nxt         = '0;
                snap_digits_nxt = scan.digits_bcd;
                snap_lz_nxt     = scan.lz_suppress;
                snap_mask_nxt   = scan.blank_mask;
                tick_nxt        = 1'b1;
            end else if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                idx_nxt = idx + 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            state_nxt = (int'(cnt_nxt) < BLANK_CYC) ? BLANK : SHOW;
        end
    end

    // Blanking is evaluated on the next snapshot so a frame starting directly in SHOW uses fresh data.
    seg_lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .digits      (snap_digits_nxt),
        .lz_suppress (snap_lz_nxt),
        .blank_mask  (snap_mask_nxt),
        .blank       (blank_vec)
    );

    always_comb begin
        an_nxt  = '1;
        bcd_nxt = BCD_BLANK;
        if (state_nxt == SHOW) begin
            an_nxt[idx_nxt] = 1'b0;
            if (!blank_vec[idx_nxt]) begin
                bcd_nxt = snap_digits_nxt[4*idx_nxt +: 4];
            end
        end
    end

    assign scan.an_n       = an_q;
    assign scan.bcd_out    = bcd_q;
    assign scan.digit_idx  = idx;
    assign scan.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: frame-position model over two builds (BLANK_CYC=2 and 0) plus pinned literals.
module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int DV    = 8;
    localparam int FRAME = ND * DV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    seg_scan_mux_if #(.DIGITS(ND)) io2 ();
    seg_scan_mux_if #(.DIGITS(ND)) io0 ();

    seg_scan_mux #(.DIGITS(ND), .DIV(DV), .BLANK_CYC(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (io2.slave)
    );

    seg_scan_mux #(.DIGITS(ND), .DIV(DV), .BLANK_CYC(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (io0.slave)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic e, input logic [15:0] d, input logic lz, input logic [3:0] m);
        io2.en = e; io2.digits_bcd = d; io2.lz_suppress = lz; io2.blank_mask = m;
        io0.en = e; io0.digits_bcd = d; io0.lz_suppress = lz; io0.blank_mask = m;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: position p counts cycles since the scan was enabled; the snapshot is taken every FRAME cycles.
    int          p   = 0;
    bit          act = 1'b0;
    logic [15:0] sd  = '0;
    logic        slz = 1'b0;
    logic [3:0]  sm  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) act = 1'b0;
        else if (!io2.en) act = 1'b0;
        else begin
            if (!act) begin
                act = 1'b1;
                p   = 0;
            end else p++;
            if (p % FRAME == 0) begin
                sd = io2.digits_bcd; slz = io2.lz_suppress; sm = io2.blank_mask;
            end
        end
    end

    function automatic logic [3:0] shown(input int i);
        logic [3:0] v;
        bit allz;
        v = sd[4*i +: 4];
        if (sm[i]) return 4'hF;
        if (v > 4'd9) return 4'hF;
        if (slz && i > 0) begin
            allz = 1'b1;
            for (int j = i; j < ND; j++) if (sd[4*j +: 4] != 4'd0) allz = 1'b0;
            if (allz) return 4'hF;
        end
        return v;
    endfunction

    function automatic int e_idx();
        return act ? (p % FRAME) / DV : 0;
    endfunction

    function automatic logic [3:0] e_an(input int blank_cyc);
        logic [3:0] m;
        if (!act || (p % DV) < blank_cyc) return 4'hF;
        m = 4'b0001 << e_idx();
        return ~m;
    endfunction

    function automatic logic [3:0] e_bcd(input int blank_cyc);
        if (!act || (p % DV) < blank_cyc) return 4'hF;
        return shown(e_idx());
    endfunction

    function automatic logic e_tick();
        return act && (p % FRAME == 0);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("an_n_b2",  io2.an_n,       e_an(2));
            check("bcd_b2",   io2.bcd_out,    e_bcd(2));
            check("idx_b2",   io2.digit_idx,  e_idx());
            check("tick_b2",  io2.frame_tick, e_tick());
            check("an_n_b0",  io0.an_n,       e_an(0));
            check("bcd_b0",   io0.bcd_out,    e_bcd(0));
            check("idx_b0",   io0.digit_idx,  e_idx());
            check("tick_b0",  io0.frame_tick, e_tick());
            if (act) check("an_dark_b0", io0.an_n == 4'hF, 1'b0);
        end
    end

    task automatic lit(input string nm, input logic [3:0] an, input logic [3:0] bcd);
        check({nm, "_an"},  io2.an_n,    an);
        check({nm, "_bcd"}, io2.bcd_out, bcd);
    endtask

    initial begin
        set_in(1'b0, 16'h0000, 1'b0, 4'b0000);
        #1 rst_n = 1'b0;
        step(3);
        chk_on = 1'b1;
        lit("reset", 4'hF, 4'hF);
        check("reset_idx",  io2.digit_idx,  0);
        check("reset_tick", io2.frame_tick, 0);
        rst_n = 1'b1;
        step(1);

        // Plain scan of 1234
        set_in(1'b1, 16'h1234, 1'b0, 4'b0000);
        step(1);  check("t1_tick0", io2.frame_tick, 1); lit("t1_p0", 4'hF, 4'hF);
        step(2);  lit("t1_p2", 4'hE, 4'h4);
        step(8);  lit("t1_p10", 4'hD, 4'h3);
        step(22); check("t1_tick32", io2.frame_tick, 1); check("t1_idx32", io2.digit_idx, 0);

        // Mid-frame change must not tear the frame
        set_in(1'b1, 16'h5678, 1'b0, 4'b0000);
        step(4);  lit("t3_old", 4'hE, 4'h4);
        step(30); lit("t3_new", 4'hE, 4'h8);

        // Leading-zero suppression
        set_in(1'b1, 16'h0050, 1'b1, 4'b0000);
        step(32); lit("t2_d0", 4'hE, 4'h0);
        step(8);  lit("t2_d1", 4'hD, 4'h5);
        step(8);  lit("t2_d2", 4'hB, 4'hF);
        step(8);  lit("t2_d3", 4'h7, 4'hF);
        set_in(1'b1, 16'h0000, 1'b1, 4'b0000);
        step(8);  lit("t2_z0", 4'hE, 4'h0);
        step(8);  lit("t2_z1", 4'hD, 4'hF);

        // Forced mask and illegal BCD
        set_in(1'b1, 16'h123C, 1'b0, 4'b0100);
        step(24); lit("t4_d0", 4'hE, 4'hF);
        step(8);  lit("t4_d1", 4'hD, 4'h3);
        step(8);  lit("t4_d2", 4'hB, 4'hF);

        // Drop enable mid-SHOW, then re-enable
        step(2);
        set_in(1'b0, 16'h123C, 1'b0, 4'b0100);
        step(1);  lit("t5_off", 4'hF, 4'hF); check("t5_off_idx", io2.digit_idx, 0);
        step(3);
        set_in(1'b1, 16'h123C, 1'b0, 4'b0100);
        step(1);  check("t5_re_tick", io2.frame_tick, 1); check("t5_re_idx", io2.digit_idx, 0);
        check("t5_b0_an", io0.an_n, 4'hE);

        // Asynchronous reset pulse mid-slot
        step(5);  lit("t5_pre_rst", 4'hE, 4'hF);
        #1 rst_n = 1'b0;
        #1 lit("t5_rst", 4'hF, 4'hF);
        check("t5_rst_b0_an", io0.an_n, 4'hF);
        check("t5_rst_tick",  io0.frame_tick, 0);
        step(2);
        rst_n = 1'b1;
        step(1);  check("t5_rel_tick", io2.frame_tick, 1);

        set_in(1'b1, 16'h9876, 1'b0, 4'b0000);
        step(70);
        set_in(1'b0, 16'h9876, 1'b0, 4'b0000);
        step(3);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
